// File: rtl/synth_midi_pkg.sv
// Shared types and constants for the synthesizer MIDI event path.
// Used by the parser top module and by its event FIFO.
package synth_midi_pkg;

  typedef enum logic [2:0] {
    EV_NOTE_OFF = 3'd0,
    EV_NOTE_ON  = 3'd1,
    EV_POLY_AT  = 3'd2,
    EV_CC       = 3'd3,
    EV_PROG     = 3'd4,
    EV_CH_AT    = 3'd5,
    EV_BEND     = 3'd6,
    EV_NONE     = 3'd7
  } ev_type_e;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_WAIT_D1,
    PS_WAIT_D2,
    PS_SYSEX
  } parse_state_e;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CH_AT    = 4'hD;
  localparam logic [3:0] ST_BEND     = 4'hE;

  localparam logic [7:0] SYX_START = 8'hF0;
  localparam logic [7:0] SYX_END   = 8'hF7;
  localparam logic [7:0] RT_FIRST  = 8'hF8;

  typedef struct packed {
    ev_type_e   etype;
    logic [3:0] ch;
    logic [6:0] d1;
    logic [6:0] d2;
  } midi_event_t;

  localparam int EVENT_W = $bits(midi_event_t);

  function automatic ev_type_e nibble_to_type(input logic [3:0] nib);
    case (nib)
      ST_NOTE_OFF: return EV_NOTE_OFF;
      ST_NOTE_ON:  return EV_NOTE_ON;
      ST_POLY_AT:  return EV_POLY_AT;
      ST_CC:       return EV_CC;
      ST_PROG:     return EV_PROG;
      ST_CH_AT:    return EV_CH_AT;
      ST_BEND:     return EV_BEND;
      default:     return EV_NONE;
    endcase
  endfunction

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic is_one_data_byte(input logic [3:0] nib);
    return (nib == ST_PROG) || (nib == ST_CH_AT);
  endfunction

endpackage

// File: rtl/midi_event_fifo.sv
// First-word fall-through event FIFO with wrap-bit pointers and a level count.
// The head reads as zero while empty so downstream fields are clean after reset.
module midi_event_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/midi_event_decoder.sv
// Channel-voice MIDI parser with running status, channel filtering and a
// buffered typed-event output stream.
module midi_event_decoder
  import synth_midi_pkg::*;
#(
  parameter int CHANNELS   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           CLOCK_50,
  input  logic                           reset_reg,
  input  logic                           byteready,
  input  logic [7:0]                     midi_in_data,
  input  logic [3:0]                     base_ch,
  input  logic                           omni,
  output logic                           ev_valid,
  input  logic                           ev_ready,
  output logic [2:0]                     ev_type,
  output logic [3:0]                     ev_ch,
  output logic [6:0]                     ev_data1,
  output logic [6:0]                     ev_data2,
  output logic signed [13:0]             ev_bend,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [7:0]                     drop_cnt
);

  localparam logic [4:0] CH_LIMIT = 5'(CHANNELS);

  parse_state_e         state;
  parse_state_e         state_next;
  logic [3:0]           rs_nib;
  logic [3:0]           rs_ch;
  logic [6:0]           d1_q;
  logic                 status_load;
  logic                 d1_load;
  logic                 msg_done;
  logic [4:0]           ch_offset;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  midi_event_t          ev_new;
  midi_event_t          ev_head;
  logic [EVENT_W-1:0]   head_bits;

  // {msb,lsb} - 8192 modulo 2^14 is the 14-bit word with its top bit inverted.
  function automatic logic signed [13:0] bend_value(input logic [6:0] msb,
                                                    input logic [6:0] lsb);
    return {~msb[6], msb[5:0], lsb};
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (reset_reg) begin
      state  <= PS_IDLE;
      rs_nib <= '0;
      rs_ch  <= '0;
    end else begin
      state <= state_next;
      if (status_load) begin
        rs_nib <= midi_in_data[7:4];
        rs_ch  <= midi_in_data[3:0];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (d1_load) d1_q <= midi_in_data[6:0];
  end

  always_comb begin
    state_next  = state;
    status_load = 1'b0;
    d1_load     = 1'b0;
    msg_done    = 1'b0;
    if (byteready && !reset_reg && (midi_in_data < RT_FIRST)) begin
      if (midi_in_data[7]) begin
        if (midi_in_data < SYX_START) begin
          status_load = 1'b1;
          state_next  = PS_WAIT_D1;
        end else if (midi_in_data == SYX_START) begin
          state_next = PS_SYSEX;
        end else begin
          state_next = PS_IDLE;
        end
      end else begin
        case (state)
          PS_WAIT_D1: begin
            d1_load = 1'b1;
            if (is_one_data_byte(rs_nib)) msg_done = 1'b1;
            else                          state_next = PS_WAIT_D2;
          end
          PS_WAIT_D2: begin
            msg_done   = 1'b1;
            state_next = PS_WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ev_new.etype = nibble_to_type(rs_nib);
    ev_new.ch    = rs_ch;
    if (state == PS_WAIT_D1) begin
      ev_new.d1 = midi_in_data[6:0];
      ev_new.d2 = '0;
    end else begin
      ev_new.d1 = d1_q;
      ev_new.d2 = midi_in_data[6:0];
    end
    if ((ev_new.etype == EV_NOTE_ON) && (ev_new.d2 == 7'd0)) ev_new.etype = EV_NOTE_OFF;
  end

  // The offset is taken in 5 bits so channels below base_ch never wrap into range.
  assign ch_offset = {1'b0, rs_ch} - {1'b0, base_ch};
  assign accept    = omni || (!ch_offset[4] && (ch_offset < CH_LIMIT));
  assign push      = msg_done && accept;
  assign pop       = ev_valid && ev_ready;

  always_ff @(posedge CLOCK_50) begin
    if (reset_reg) begin
      drop_cnt <= '0;
    end else if (push && fifo_full && !pop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  midi_event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst   (reset_reg),
    .push  (push),
    .pop   (pop),
    .wdata (ev_new),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign ev_head  = midi_event_t'(head_bits);
  assign ev_valid = !fifo_empty;
  assign ev_type  = ev_head.etype;
  assign ev_ch    = ev_head.ch;
  assign ev_data1 = ev_head.d1;
  assign ev_data2 = ev_head.d2;
  assign ev_bend  = bend_value(ev_head.d2, ev_head.d1);

endmodule

// File: tb/tb_midi_event_decoder.sv
// Bench for midi_event_decoder: directed scenarios plus random byte streams
// checked against a message-level reference model with a queue-based FIFO.
module tb_midi_event_decoder;

  localparam int CH    = 4;
  localparam int DEPTH = 8;

  logic               clk = 1'b0;
  logic               reset_reg = 1'b1;
  logic               byteready = 1'b0;
  logic [7:0]         midi_in_data = 8'h00;
  logic [3:0]         base_ch = 4'd0;
  logic               omni = 1'b1;
  logic               ev_valid;
  logic               ev_ready = 1'b0;
  logic [2:0]         ev_type;
  logic [3:0]         ev_ch;
  logic [6:0]         ev_data1;
  logic [6:0]         ev_data2;
  logic signed [13:0] ev_bend;
  logic [3:0]         fifo_level;
  logic [7:0]         drop_cnt;

  always #5 clk = ~clk;

  midi_event_decoder #(.CHANNELS(CH), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50(clk), .reset_reg(reset_reg), .byteready(byteready),
    .midi_in_data(midi_in_data), .base_ch(base_ch), .omni(omni),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_ch(ev_ch),
    .ev_data1(ev_data1), .ev_data2(ev_data2), .ev_bend(ev_bend),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  typedef struct { int t; int ch; int d1; int d2; } ev_t;

  int  n_checks = 0;
  int  n_pass = 0;
  int  m_rs = -1;
  int  m_data[$];
  ev_t mq[$];
  int  m_drop = 0;

  // Message-level model: a running status byte and the data bytes gathered so far.
  function automatic bit model_byte(input int b, output ev_t e);
    int hi;
    int need;
    e = '{0, 0, 0, 0};
    if (b >= 248) return 0;
    if (b >= 240) begin m_rs = -1; m_data.delete(); return 0; end
    if (b >= 128) begin m_rs = b; m_data.delete(); return 0; end
    if (m_rs < 0) return 0;
    m_data.push_back(b);
    hi = m_rs / 16;
    need = (hi == 12 || hi == 13) ? 1 : 2;
    if (m_data.size() < need) return 0;
    e.t  = hi - 8;
    e.ch = m_rs % 16;
    e.d1 = m_data[0];
    e.d2 = (need == 2) ? m_data[1] : 0;
    if (e.t == 1 && e.d2 == 0) e.t = 0;
    m_data.delete();
    return 1;
  endfunction

  function automatic bit model_accept(input int ch);
    int off;
    off = ch - int'(base_ch);
    return omni || (off >= 0 && off < CH);
  endfunction

  task automatic model_clear();
    m_rs = -1;
    m_data.delete();
    mq.delete();
    m_drop = 0;
  endtask

  // One clock with the given inputs; entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit br, input int b, input bit rdy);
    bit  pop;
    bit  done;
    ev_t e;
    byteready = br;
    midi_in_data = 8'(b);
    ev_ready = rdy;
    @(negedge clk);
    pop = rdy && (mq.size() > 0);
    done = br ? model_byte(b, e) : 1'b0;
    @(posedge clk);
    #1;
    byteready = 1'b0;
    if (pop) void'(mq.pop_front());
    if (done && model_accept(e.ch)) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic send(input int b);
    cycle(1'b1, b, 1'b0);
  endtask

  task automatic do_reset();
    reset_reg = 1'b1;
    byteready = 1'b1;
    midi_in_data = 8'h3C;
    @(posedge clk);
    #1;
    reset_reg = 1'b0;
    byteready = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (ev_valid !== 1'b0) $display("FAIL reset_valid got %0d want 0", ev_valid); else n_pass++;
    n_checks++; if (ev_type !== 3'd0) $display("FAIL reset_type got %0d want 0", ev_type); else n_pass++;
    n_checks++; if (ev_ch !== 4'd0) $display("FAIL reset_ch got %0d want 0", ev_ch); else n_pass++;
    n_checks++; if (ev_data1 !== 7'd0 || ev_data2 !== 7'd0) $display("FAIL reset_data got %0d/%0d want 0/0", ev_data1, ev_data2); else n_pass++;
    n_checks++; if (ev_bend !== -14'sd8192) $display("FAIL reset_bend got %0d want -8192", ev_bend); else n_pass++;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else n_pass++;
  endtask

  task automatic test_running_status();
    omni = 1'b1;
    send(8'h90); send(8'h3C); send(8'h64);
    n_checks++; if (ev_valid !== 1'b1 || fifo_level !== 4'd1) $display("FAIL rs_latency got valid=%0d level=%0d want 1/1", ev_valid, fifo_level); else n_pass++;
    send(8'h3E); send(8'h00);
    n_checks++; if (fifo_level !== 4'd2) $display("FAIL rs_level got %0d want 2", fifo_level); else n_pass++;
    n_checks++; if ({ev_type, ev_ch, ev_data1, ev_data2} !== {3'd1, 4'd0, 7'd60, 7'd100}) $display("FAIL rs_note_on got t=%0d ch=%0d %0d/%0d want 1 0 60/100", ev_type, ev_ch, ev_data1, ev_data2); else n_pass++;
    cycle(1'b0, 0, 1'b1);
    n_checks++; if ({ev_type, ev_ch, ev_data1, ev_data2} !== {3'd0, 4'd0, 7'd62, 7'd0}) $display("FAIL rs_note_off got t=%0d ch=%0d %0d/%0d want 0 0 62/0", ev_type, ev_ch, ev_data1, ev_data2); else n_pass++;
    cycle(1'b0, 0, 1'b1);
    n_checks++; if (ev_valid !== 1'b0 || fifo_level !== 4'd0) $display("FAIL rs_drain got valid=%0d level=%0d want 0/0", ev_valid, fifo_level); else n_pass++;
  endtask

  task automatic test_bend();
    send(8'hE3); send(8'h00); send(8'h40);
    n_checks++; if ({ev_type, ev_ch, ev_data1, ev_data2} !== {3'd6, 4'd3, 7'd0, 7'h40}) $display("FAIL bend_fields got t=%0d ch=%0d %0d/%0d want 6 3 0/64", ev_type, ev_ch, ev_data1, ev_data2); else n_pass++;
    n_checks++; if (ev_bend !== 14'sd0) $display("FAIL bend_center got %0d want 0", ev_bend); else n_pass++;
    cycle(1'b0, 0, 1'b1);
    send(8'hE3); send(8'h7F); send(8'h7F);
    n_checks++; if (ev_bend !== 14'sd8191) $display("FAIL bend_max got %0d want 8191", ev_bend); else n_pass++;
    cycle(1'b0, 0, 1'b1);
    send(8'hE0); send(8'h00); send(8'h00);
    n_checks++; if (ev_bend !== -14'sd8192) $display("FAIL bend_min got %0d want -8192", ev_bend); else n_pass++;
    cycle(1'b0, 0, 1'b1);
  endtask

  task automatic test_filter();
    omni = 1'b0;
    base_ch = 4'd14;
    send(8'hCF); send(8'h05); send(8'hC0); send(8'h05);
    n_checks++; if (fifo_level !== 4'd1) $display("FAIL filter_level got %0d want 1", fifo_level); else n_pass++;
    n_checks++; if ({ev_type, ev_ch, ev_data1, ev_data2} !== {3'd4, 4'd15, 7'd5, 7'd0}) $display("FAIL filter_prog got t=%0d ch=%0d %0d/%0d want 4 15 5/0", ev_type, ev_ch, ev_data1, ev_data2); else n_pass++;
    cycle(1'b0, 0, 1'b1);
    n_checks++; if (ev_valid !== 1'b0 || drop_cnt !== 8'd0) $display("FAIL filter_nowrap got valid=%0d drop=%0d want 0/0", ev_valid, drop_cnt); else n_pass++;
    base_ch = 4'd2;
    send(8'hD5); send(8'h11); send(8'hD6); send(8'h22);
    n_checks++; if (fifo_level !== 4'd1 || ev_ch !== 4'd5 || ev_type !== 3'd5) $display("FAIL filter_upper got level=%0d ch=%0d t=%0d want 1 5 5", fifo_level, ev_ch, ev_type); else n_pass++;
    cycle(1'b0, 0, 1'b1);
    omni = 1'b1;
  endtask

  task automatic test_realtime();
    send(8'hB1); send(8'h07); send(8'hF8); send(8'h64);
    n_checks++; if ({ev_valid, ev_type, ev_ch, ev_data1, ev_data2} !== {1'b1, 3'd3, 4'd1, 7'd7, 7'd100}) $display("FAIL realtime_cc got v=%0d t=%0d ch=%0d %0d/%0d want 1 3 1 7/100", ev_valid, ev_type, ev_ch, ev_data1, ev_data2); else n_pass++;
    cycle(1'b0, 0, 1'b1);
  endtask

  task automatic test_sysex();
    send(8'hF0); send(8'h43); send(8'h10); send(8'hF7); send(8'h40); send(8'h41);
    n_checks++; if (ev_valid !== 1'b0 || fifo_level !== 4'd0) $display("FAIL sysex_quiet got valid=%0d level=%0d want 0/0", ev_valid, fifo_level); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(8'hB0); send(i); send(i + 20);
    end
    n_checks++; if (fifo_level !== 4'd8) $display("FAIL overflow_level got %0d want 8", fifo_level); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd2) $display("FAIL overflow_drop got %0d want 2", drop_cnt); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (ev_valid !== 1'b1 || ev_data1 !== 7'(i) || fifo_level !== 4'(8 - i)) $display("FAIL drain_%0d got valid=%0d d1=%0d level=%0d want 1 %0d %0d", i, ev_valid, ev_data1, fifo_level, i, 8 - i); else n_pass++;
      cycle(1'b0, 0, 1'b1);
    end
    n_checks++; if (ev_valid !== 1'b0) $display("FAIL drain_end got valid=%0d want 0", ev_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    send(8'hB0); send(8'h01); send(8'h02); send(8'h90); send(8'h3C);
    do_reset();
    n_checks++; if (ev_valid !== 1'b0 || fifo_level !== 4'd0) $display("FAIL midreset_flush got valid=%0d level=%0d want 0/0", ev_valid, fifo_level); else n_pass++;
    send(8'h40); send(8'h40);
    n_checks++; if (ev_valid !== 1'b0) $display("FAIL midreset_partial got valid=%0d want 0", ev_valid); else n_pass++;
  endtask

  task automatic test_random();
    int  b;
    int  r;
    ev_t h;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) begin
        omni = ($urandom_range(0, 1) == 1);
        base_ch = 4'($urandom_range(0, 15));
      end
      r = $urandom_range(0, 99);
      if (r < 25)      b = $urandom_range(128, 239);
      else if (r < 85) b = $urandom_range(0, 127);
      else if (r < 90) b = $urandom_range(248, 255);
      else if (r < 94) b = 240;
      else             b = $urandom_range(241, 247);
      cycle($urandom_range(0, 9) < 8, b, $urandom_range(0, 9) < 4);
      n_checks++; if (ev_valid !== (mq.size() > 0)) $display("FAIL rand_valid n=%0d got %0d want %0d", n, ev_valid, mq.size() > 0); else n_pass++;
      n_checks++; if (fifo_level !== 4'(mq.size()) || drop_cnt !== 8'(m_drop)) $display("FAIL rand_level n=%0d got %0d/%0d want %0d/%0d", n, fifo_level, drop_cnt, mq.size(), m_drop); else n_pass++;
      if (mq.size() > 0) begin
        h = mq[0];
        n_checks++;
        if (ev_type !== 3'(h.t) || ev_ch !== 4'(h.ch) || ev_data1 !== 7'(h.d1) || ev_data2 !== 7'(h.d2) || int'(ev_bend) !== h.d2 * 128 + h.d1 - 8192)
          $display("FAIL rand_head n=%0d got t=%0d ch=%0d %0d/%0d bend=%0d want t=%0d ch=%0d %0d/%0d", n, ev_type, ev_ch, ev_data1, ev_data2, ev_bend, h.t, h.ch, h.d1, h.d2);
        else n_pass++;
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_running_status();
    test_bend();
    test_filter();
    test_realtime();
    test_sysex();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
